// File: rtl/if_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// Used by if_fetch and, when IF_PERF_CNT_EN is defined, if_perf_cnt.
package if_pkg;

  localparam logic [15:0] RESET_PC   = 16'h0000;
  localparam logic [15:0] NOP_INSTR  = 16'h0800;
  localparam logic [3:0]  WAIT_LIMIT = 4'd15;

  typedef logic [1:0] state_t;
  localparam state_t ST_BOOT = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;

endpackage

// File: rtl/if_perf_cnt.sv
// Saturating 16-bit performance counters for granted fetches and redirects.
// Built only when the top is compiled with IF_PERF_CNT_EN.
module if_perf_cnt
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        redir_inc,
  output logic [15:0] perf_fetch,
  output logic [15:0] perf_redir
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch <= 16'h0000;
      perf_redir <= 16'h0000;
    end else begin
      if (fetch_inc && perf_fetch != 16'hFFFF) perf_fetch <= perf_fetch + 16'd1;
      if (redir_inc && perf_redir != 16'hFFFF) perf_redir <= perf_redir + 16'd1;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, SRAM read handshake and IF/ID register.
// Optional performance counters are enabled with the IF_PERF_CNT_EN macro.
module if_fetch
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pred_pc,
  output logic [15:0] cur_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [15:0] mem_rdata,
  output logic        id_valid,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc,
  output logic [15:0] id_npc,
  output logic        fetch_err,
  output logic [15:0] perf_fetch,
  output logic [15:0] perf_redir
);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       active;

  assign active   = (state != ST_BOOT);
  assign mem_req  = active & ~stall & ~rst;
  assign mem_addr = cur_pc;

  // Priority inside RUN/WAIT: redirect, then stall, then grant/no-grant.
  // NOTE: every register here uses non-blocking assignments so all of them
  // update from the same pre-edge values, and all are cleared by the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_BOOT;
      cur_pc    <= RESET_PC;
      id_valid  <= 1'b0;
      id_instr  <= NOP_INSTR;
      id_pc     <= 16'h0000;
      id_npc    <= 16'h0000;
      wait_cnt  <= 4'd0;
      fetch_err <= 1'b0;
    end else if (!active) begin
      state <= ST_RUN;
    end else if (redirect) begin
      cur_pc   <= redirect_pc;
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      state    <= ST_RUN;
      wait_cnt <= 4'd0;
    end else if (!stall) begin
      if (mem_gnt) begin
        id_instr <= mem_rdata;
        id_pc    <= cur_pc;
        id_npc   <= cur_pc + 16'd1;
        id_valid <= 1'b1;
        cur_pc   <= pred_pc;
        state    <= ST_RUN;
        wait_cnt <= 4'd0;
      end else begin
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
        state    <= ST_WAIT;
        // Starvation past the saturated count is latched until reset.
        if (wait_cnt == WAIT_LIMIT) fetch_err <= 1'b1;
        else                        wait_cnt  <= wait_cnt + 4'd1;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic fetch_event;
  logic redir_event;

  assign fetch_event = mem_req & mem_gnt & ~redirect;
  assign redir_event = active & redirect;

  if_perf_cnt u_perf_cnt (
    .clk        (clk),
    .rst        (rst),
    .fetch_inc  (fetch_event),
    .redir_inc  (redir_event),
    .perf_fetch (perf_fetch),
    .perf_redir (perf_redir)
  );
`else
  assign perf_fetch = 16'h0000;
  assign perf_redir = 16'h0000;
`endif

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 pred_pc  input  16  predicted next PC from the branch target buffer for the current cur_pc.
REQ-005 cur_pc  output  16  current fetch PC; drives the branch target buffer lookup and the memory address.
REQ-006 redirect  input  1  misprediction flush from branch resolution.
REQ-007 redirect_pc  input  16  corrected fetch PC, valid with redirect.
REQ-008 stall  input  1  hazard-unit hold request for IF and IF/ID.
REQ-009 mem_req  output  1  instruction read request to the shared SRAM arbiter.
REQ-010 mem_addr  output  16  read address; always equals cur_pc.
REQ-011 mem_gnt  input  1  arbiter grant; mem_rdata is valid in the same cycle as mem_req & mem_gnt.
REQ-012 mem_rdata  input  16  instruction word.
REQ-013 id_valid / id_instr / id_pc / id_npc  output  1/16/16/16  IF/ID register contents; id_npc = id_pc+1.
REQ-014 fetch_err  output  1  sticky flag for grant starvation.
REQ-015 perf_fetch / perf_redir  output  16/16  performance counters.

Function
REQ-016 States SHALL be BOOT, RUN, WAIT; BOOT lasts exactly one cycle, then RUN; mem_req=0 in BOOT.
REQ-017 Per-cycle priority in RUN/WAIT SHALL be redirect > stall > grant.
REQ-018 On redirect: cur_pc<=redirect_pc, id_valid<=0, id_instr<=NOP, state<=RUN, wait counter cleared, regardless of stall or mem_gnt.
REQ-019 On stall without redirect: mem_req=0, cur_pc and all id_* registers hold, state and wait counter hold.
REQ-020 In RUN/WAIT without stall: mem_req=1.
REQ-021 On mem_gnt: id_instr<=mem_rdata, id_pc<=cur_pc, id_npc<=cur_pc+1, id_valid<=1, cur_pc<=pred_pc, state<=RUN, wait counter cleared.
REQ-022 On no grant: cur_pc holds, id_valid<=0, id_instr<=NOP (bubble), state<=WAIT, and the 4-bit wait counter increments, saturating at 15.
REQ-023 fetch_err SHALL set when the wait counter is 15 and another ungranted cycle occurs; it clears only on reset.
REQ-024 Fetch latency SHALL be one cycle: an instruction granted in cycle n appears on id_* in cycle n+1.
REQ-025 id_npc SHALL wrap modulo 2^16 (16'hFFFF -> 16'h0000).
REQ-026 pred_pc SHALL be used unmodified; the block performs no target checking.

Reset
REQ-027 On rst: cur_pc=RESET_PC (16'h0000), state=BOOT, id_valid=0, id_instr=NOP (16'h0800), id_pc=0, id_npc=0, wait counter=0, fetch_err=0, perf counters=0; mem_req=0 while rst is high.
REQ-028 rst asserted mid-fetch SHALL discard any granted data in that cycle.

Configuration
REQ-029 With IF_PERF_CNT_EN defined: perf_fetch counts granted fetches and perf_redir counts redirect cycles, both 16-bit and saturating at 16'hFFFF.
REQ-030 Without IF_PERF_CNT_EN: perf_fetch and perf_redir remain ports and are tied to 0; no counter flops are built.

Structure
REQ-031 Shared package if_pkg SHALL hold RESET_PC, NOP_INSTR, WAIT_LIMIT (4'd15), and the state enumeration.
REQ-032 Counters SHALL live in sub-module if_perf_cnt, instantiated only under IF_PERF_CNT_EN.

Verification
REQ-033 Reset, then mem_gnt=1, mem_rdata=16'h4801, pred_pc=cur_pc+1 -> mem_req low for 1 cycle; then id_pc=0, id_instr=16'h4801, id_npc=1, cur_pc=1.
REQ-034 pred_pc=16'h0040 at cur_pc=16'h0005 with grant -> next cycle cur_pc=16'h0040, id_pc=16'h0005.
REQ-035 stall=1 and redirect=1 with redirect_pc=16'h0100 -> next cycle cur_pc=16'h0100, id_valid=0, id_instr=16'h0800.
REQ-036 stall=1 for 3 cycles -> mem_req=0 and id_*/cur_pc unchanged for the whole stall; fetch resumes on release.
REQ-037 mem_gnt=0 for 17 cycles -> id_valid=0 throughout; fetch_err=1 from cycle 17 onward, and still 1 after a later grant.
REQ-038 cur_pc=16'hFFFF granted -> id_npc=16'h0000; with IF_PERF_CNT_EN, perf_fetch increments by 1.
